// File: rtl/shifter_4b_rseq.sv
// ============================================================================
// shifter_4b_rseq : sequential right shifter, one position per clock, with
// fill-bit insertion and shifted-out bit collection. Optional: SHIFTER_RSEQ_ROTATE_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module shifter_4b_rseq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amt,
  input  logic             fill,
`ifdef SHIFTER_RSEQ_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] n_lat;
  logic [AMT_W-1:0] k;
  logic             fill_lat;
  logic [AMT_W-1:0] amt_eff;
  logic             ins_bit;

  // Amounts beyond the last bit position saturate (only reachable for non-power-of-two WIDTH).
  always_comb begin
    amt_eff = amt;
    if (int'(amt) > WIDTH - 1) amt_eff = AMT_W'(WIDTH - 1);
  end

`ifdef SHIFTER_RSEQ_ROTATE_EN
  logic rot_lat;
  always_comb ins_bit = rot_lat ? X[0] : fill_lat;
`else
  always_comb ins_bit = fill_lat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      X        <= '0;
      Y        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      n_lat    <= '0;
      k        <= '0;
      fill_lat <= 1'b0;
`ifdef SHIFTER_RSEQ_ROTATE_EN
      rot_lat  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            X        <= A;
            Y        <= '0;
            k        <= '0;
            n_lat    <= amt_eff;
            fill_lat <= fill;
`ifdef SHIFTER_RSEQ_ROTATE_EN
            rot_lat  <= rotate;
`endif
            if (amt_eff == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          X    <= {ins_bit, X[WIDTH-1:1]};
          Y[k] <= X[0];
          k    <= k + AMT_W'(1);
          if (k == n_lat - AMT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
